// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. It arbitrates
// data-memory wait, MDU occupancy of EX, taken-branch flush and load-use
// hazards. It drives the pipeline-register enables combinationally from the
// state and the current inputs, and it counts the cycles in which the PC was
// held.
module pipeline_stall_ctrl #(
    parameter int MDU_LAT = 4,   // total cycles an MDU op occupies EX (>= 2)
    parameter int CNT_W   = 16   // width of the saturating stall-cycle counter
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_AddrA,
    input  logic [4:0]       id_AddrB,
    input  logic             id_UsesB,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_BranchTaken,
    input  logic             ex_MduStart,
    input  logic             mem_Access,
    input  logic             mem_Ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_Hold,
    output logic             MEM_Hold,
    output logic             MduDone,
    output logic             ctrl_State,
    output logic [CNT_W-1:0] stall_cnt
);

    // The MDU countdown only has to hold MDU_LAT-2. The start cycle and the
    // release cycle are not counted.
    localparam int MC_W = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
    localparam logic [MC_W-1:0] MDU_LOAD = MC_W'(MDU_LAT - 2);

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [MC_W-1:0]   mdu_cnt, mdu_cnt_nxt;
    logic              mem_wait;
    logic              load_use;
    logic              rs1_match;
    logic              rs2_match;

    // The counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Hazard decode. x0 never creates a load-use dependency.
    always_comb begin
        mem_wait  = mem_Access & ~mem_Ready;
        rs1_match = (ex_rd == id_AddrA);
        rs2_match = id_UsesB & (ex_rd == id_AddrB);
        load_use  = ex_MemRead & (ex_rd != 5'd0) & (rs1_match | rs2_match);
    end

    // Prioritised next-state logic and Mealy output logic. Memory wait beats
    // the MDU, which beats branch flush, which beats load-use.
    always_comb begin
        state_nxt    = state;
        mdu_cnt_nxt  = mdu_cnt;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_Hold      = 1'b0;
        MEM_Hold     = 1'b0;
        MduDone      = 1'b0;

        if (rst) begin
            // Hold fetch and feed NOPs while the pipeline is in reset.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt    = RUN;
            mdu_cnt_nxt  = '0;
        end else if (mem_wait) begin
            // Freeze everything, including the MDU sequence, until memory answers.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            EX_Hold     = 1'b1;
            MEM_Hold    = 1'b1;
        end else if (state == MDU) begin
            if (mdu_cnt != '0) begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                EX_Hold     = 1'b1;
                mdu_cnt_nxt = mdu_cnt - MC_W'(1);
            end else begin
                // Last occupancy cycle: the result is valid and EX is released.
                MduDone   = 1'b1;
                state_nxt = RUN;
            end
        end else if (ex_MduStart) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            EX_Hold     = 1'b1;
            state_nxt   = MDU;
            mdu_cnt_nxt = MDU_LOAD;
        end else if (ex_BranchTaken) begin
            // The PC loads the branch target. The two wrong-path slots are squashed.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (load_use) begin
            // This cycle inserts a single bubble. After it, the load has moved
            // on to MEM and the hazard is gone.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    // State register and MDU countdown. Reset aborts any MDU op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // Count the cycles in which the PC was held, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!PCWrite) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign ctrl_State = (state == MDU);

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: fixed vector table, hand
// sequences for multi-cycle corners, then randomized traffic against a
// behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Expected enable bundle: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MEM_Hold, MduDone}
    localparam logic [6:0] O_RUN  = 7'b1100000;
    localparam logic [6:0] O_LU   = 7'b0001000;
    localparam logic [6:0] O_BR   = 7'b1111000;
    localparam logic [6:0] O_HOLD = 7'b0000100;
    localparam logic [6:0] O_MW   = 7'b0000110;
    localparam logic [6:0] O_DONE = 7'b1100001;
    localparam logic [6:0] O_RST  = 7'b0011000;

    typedef struct {
        logic       rst;
        logic [4:0] a;
        logic [4:0] b;
        logic       ub;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ms;
        logic       acc;
        logic       rdy;
        logic [6:0] exp_o;
        logic       exp_st;
        int         exp_cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       id_AddrA = '0, id_AddrB = '0, ex_rd = '0;
    logic             id_UsesB = 1'b0, ex_MemRead = 1'b0, ex_BranchTaken = 1'b0;
    logic             ex_MduStart = 1'b0, mem_Access = 1'b0, mem_Ready = 1'b0;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
    logic             EX_Hold, MEM_Hold, MduDone, ctrl_State;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: in-MDU flag, EX occupancy cycles used so far, PC-held cycles.
    bit m_mdu    = 1'b0;
    int m_age    = 0;
    int m_stalls = 0;

    pipeline_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_AddrA(id_AddrA), .id_AddrB(id_AddrB), .id_UsesB(id_UsesB),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_BranchTaken(ex_BranchTaken),
        .ex_MduStart(ex_MduStart), .mem_Access(mem_Access), .mem_Ready(mem_Ready),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .EX_Hold(EX_Hold), .MEM_Hold(MEM_Hold),
        .MduDone(MduDone), .ctrl_State(ctrl_State), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, int a, int b, logic ub, int rd, logic mr, logic br,
                                logic ms, logic acc, logic rdy, logic [6:0] eo, logic st, int cnt);
        vec_t v;
        v.rst = r; v.a = a[4:0]; v.b = b[4:0]; v.ub = ub; v.rd = rd[4:0]; v.mr = mr;
        v.br = br; v.ms = ms; v.acc = acc; v.rdy = rdy;
        v.exp_o = eo; v.exp_st = st; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then let the edge happen.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst; id_AddrA = v.a; id_AddrB = v.b; id_UsesB = v.ub; ex_rd = v.rd;
        ex_MemRead = v.mr; ex_BranchTaken = v.br; ex_MduStart = v.ms;
        mem_Access = v.acc; mem_Ready = v.rdy;
        #1;
        chk({nm, ".enables"},
            {25'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MEM_Hold, MduDone},
            {25'd0, v.exp_o});
        chk({nm, ".state"}, {31'd0, ctrl_State}, {31'd0, v.exp_st});
        chk({nm, ".stall_cnt"}, {{(32-CNT_W){1'b0}}, stall_cnt}, v.exp_cnt);
        @(posedge clk);
    endtask

    // Expected outputs, derived directly from the priority rules.
    function automatic vec_t model_fill(vec_t v);
        logic mw, lu;
        mw = v.acc & ~v.rdy;
        lu = v.mr && (v.rd != 0) && ((v.rd == v.a) || (v.ub && v.rd == v.b));
        v.exp_st  = m_mdu;
        v.exp_cnt = m_stalls;
        if (v.rst) begin
            v.exp_o = O_RST; v.exp_st = 1'b0; v.exp_cnt = 0;
        end else if (mw)                  v.exp_o = O_MW;
        else if (m_mdu)                   v.exp_o = (m_age == MDU_LAT - 1) ? O_DONE : O_HOLD;
        else if (v.ms)                    v.exp_o = O_HOLD;
        else if (v.br)                    v.exp_o = O_BR;
        else if (lu)                      v.exp_o = O_LU;
        else                              v.exp_o = O_RUN;
        return v;
    endfunction

    task automatic model_tick(input vec_t v);
        if (v.rst) begin
            m_mdu = 1'b0; m_age = 0; m_stalls = 0;
        end else begin
            if (!v.exp_o[6] && m_stalls < CNT_MAX) m_stalls++;
            if (!(v.acc & ~v.rdy)) begin
                if (m_mdu) begin
                    if (m_age == MDU_LAT - 1) m_mdu = 1'b0;
                    else m_age++;
                end else if (v.ms) begin
                    m_mdu = 1'b1; m_age = 1;
                end
            end
        end
    endtask

    vec_t tbl[16];

    initial begin
        vec_t v;
        //          rst a  b  ub rd mr br ms acc rdy  exp     st cnt
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 0);
        tbl[2]  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, O_LU,   0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 1);
        tbl[4]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, O_RUN,  0, 1);
        tbl[5]  = mk(0, 3, 7, 0, 7, 1, 0, 0, 0, 0, O_RUN,  0, 1);
        tbl[6]  = mk(0, 3, 7, 1, 7, 1, 0, 0, 0, 0, O_LU,   0, 1);
        tbl[7]  = mk(0, 5, 0, 0, 5, 1, 1, 0, 0, 0, O_BR,   0, 2);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_HOLD, 0, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HOLD, 1, 3);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HOLD, 1, 4);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DONE, 1, 5);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 5);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_MW,   0, 5);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, O_BR,   0, 6);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 0);

        #1 rst = 1'b1;
        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // MDU op with a two-cycle memory wait while one countdown step remains.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_HOLD, 0, 0), "mw_mdu.c0");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_HOLD, 1, 1), "mw_mdu.c1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MW,   1, 2), "mw_mdu.c2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MW,   1, 3), "mw_mdu.c3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HOLD, 1, 4), "mw_mdu.c4");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DONE, 1, 5), "mw_mdu.c5");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 5), "mw_mdu.c6");

        // Reset in the middle of an MDU op aborts it with no MduDone.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_HOLD, 0, 5), "rst_mdu.c0");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HOLD, 1, 6), "rst_mdu.c1");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 0), "rst_mdu.c2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 0), "rst_mdu.c3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 0), "rst_mdu.c4");

        // Stall counter saturation.
        for (int i = 0; i < 20; i++)
            apply(mk(0, 9, 0, 0, 9, 1, 0, 0, 0, 0, O_LU, 0, (i > CNT_MAX) ? CNT_MAX : i),
                  $sformatf("sat%0d", i));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, CNT_MAX), "sat.idle");

        // Randomized traffic against the model.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0);
        v = model_fill(v);
        apply(v, "rnd.rst");
        model_tick(v);
        for (int i = 0; i < 600; i++) begin
            v.rst = ($urandom_range(0, 39) == 0);
            v.a   = 5'($urandom_range(0, 7));
            v.b   = 5'($urandom_range(0, 7));
            v.ub  = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 7));
            v.mr  = ($urandom_range(0, 2) != 0);
            v.br  = ($urandom_range(0, 4) == 0);
            v.ms  = ($urandom_range(0, 5) == 0);
            v.acc = ($urandom_range(0, 2) == 0);
            v.rdy = 1'($urandom_range(0, 1));
            v = model_fill(v);
            apply(v, $sformatf("rnd%0d", i));
            model_tick(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
